// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_o flags the terminal value.
module arb_sat_counter #(
   parameter int WIDTH = 3,
   parameter int MAX   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic sat_o
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory bus between instruction fetch and the data port,
// one transaction at a time, with starvation guard, timeout and fetch flush.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_STARVE = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req_valid,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_req_ready,
   input  logic                if_flush,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_rdata,
   output logic                if_rsp_err,
   input  logic                d_req_valid,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic                d_req_we,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_be,
   output logic                d_req_ready,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rsp_rdata,
   output logic                d_rsp_err,
   output logic                bus_req_valid,
   output logic [ADDR_W-1:0]   bus_req_addr,
   output logic                bus_req_we,
   output logic [DATA_W-1:0]   bus_req_wdata,
   output logic [DATA_W/8-1:0] bus_req_be,
   input  logic                bus_req_ready,
   input  logic                bus_rsp_valid,
   input  logic [DATA_W-1:0]   bus_rsp_rdata,
   input  logic                bus_rsp_err,
   output logic                busy
);

   localparam int BE_W = DATA_W / 8;

   arb_state_e          state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic                drop_q, drop_d;
   logic                if_rsp_valid_q, d_rsp_valid_q;
   logic [DATA_W-1:0]   if_rsp_rdata_q, d_rsp_rdata_q;
   logic                if_rsp_err_q, d_rsp_err_q;

   logic                rsp_fire;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_err;
   logic                if_fire, d_fire;
   logic                in_idle, fetch_wins, starve_sat, tmo_sat;

   assign in_idle      = (state_q == IDLE);
   assign fetch_wins   = if_req_valid & (~d_req_valid | starve_sat);
   assign if_req_ready = in_idle & fetch_wins;
   assign d_req_ready  = in_idle & d_req_valid & ~fetch_wins;

   // Counts consecutive arbitration losses of a waiting fetch.
   arb_sat_counter #(.WIDTH(cnt_width(MAX_STARVE)), .MAX(MAX_STARVE)) u_starve_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (if_req_ready),
      .inc_i (d_req_ready & if_req_valid),
      .sat_o (starve_sat)
   );

   // Saturating at TIMEOUT-1 marks the last cycle a transaction may occupy the bus.
   arb_sat_counter #(.WIDTH(cnt_width(TIMEOUT - 1)), .MAX(TIMEOUT - 1)) u_tmo_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (in_idle),
      .inc_i (~in_idle),
      .sat_o (tmo_sat)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      drop_d    = drop_q;
      rsp_fire  = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (if_req_ready) begin
               owner_d = OWN_IF;
               addr_d  = if_req_addr;
               we_d    = 1'b0;
               wdata_d = '0;
               be_d    = '1;
               drop_d  = if_flush;
               state_d = REQ;
            end else if (d_req_ready) begin
               owner_d = OWN_D;
               addr_d  = d_req_addr;
               we_d    = d_req_we;
               wdata_d = d_req_wdata;
               be_d    = d_req_be;
               state_d = REQ;
            end
         end
         REQ: begin
            if (tmo_sat) begin
               rsp_fire = 1'b1;
               rsp_err  = 1'b1;
               state_d  = IDLE;
            end else if (bus_req_ready) begin
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            // A real response arriving on the expiry cycle takes precedence.
            if (bus_rsp_valid) begin
               rsp_fire  = 1'b1;
               rsp_rdata = bus_rsp_rdata;
               rsp_err   = bus_rsp_err;
               state_d   = IDLE;
            end else if (tmo_sat) begin
               rsp_fire = 1'b1;
               rsp_err  = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!in_idle && (owner_q == OWN_IF) && if_flush) begin
         drop_d = 1'b1;
      end
   end

   assign if_fire = rsp_fire & (owner_q == OWN_IF) & ~drop_d;
   assign d_fire  = rsp_fire & (owner_q == OWN_D);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         owner_q        <= OWN_IF;
         addr_q         <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         be_q           <= '0;
         drop_q         <= 1'b0;
         if_rsp_valid_q <= 1'b0;
         if_rsp_rdata_q <= '0;
         if_rsp_err_q   <= 1'b0;
         d_rsp_valid_q  <= 1'b0;
         d_rsp_rdata_q  <= '0;
         d_rsp_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         addr_q         <= addr_d;
         we_q           <= we_d;
         wdata_q        <= wdata_d;
         be_q           <= be_d;
         drop_q         <= drop_d;
         if_rsp_valid_q <= if_fire;
         d_rsp_valid_q  <= d_fire;
         if (if_fire) begin
            if_rsp_rdata_q <= rsp_rdata;
            if_rsp_err_q   <= rsp_err;
         end
         if (d_fire) begin
            d_rsp_rdata_q <= rsp_rdata;
            d_rsp_err_q   <= rsp_err;
         end
      end
   end

   assign if_rsp_valid  = if_rsp_valid_q;
   assign if_rsp_rdata  = if_rsp_rdata_q;
   assign if_rsp_err    = if_rsp_err_q;
   assign d_rsp_valid   = d_rsp_valid_q;
   assign d_rsp_rdata   = d_rsp_rdata_q;
   assign d_rsp_err     = d_rsp_err_q;
   assign bus_req_valid = (state_q == REQ);
   assign bus_req_addr  = addr_q;
   assign bus_req_we    = we_q;
   assign bus_req_wdata = wdata_q;
   assign bus_req_be    = be_q;
   assign busy          = ~in_idle;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int MS  = 4;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid, if_rsp_err;
   logic [31:0] if_req_addr, if_rsp_rdata;
   logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
   logic [3:0]  d_req_be, bus_req_be;
   logic        bus_req_valid, bus_req_we, bus_req_ready, bus_rsp_valid, bus_rsp_err, busy;
   logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;

   int checks = 0;
   int failures = 0;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(MS), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
      .if_rsp_err(if_rsp_err),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
      .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
      .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we),
      .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be), .bus_req_ready(bus_req_ready),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req_valid = 0; if_req_addr = 0; if_flush = 0;
      d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0; d_req_be = 0;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0; bus_rsp_err = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 reset = 1'b1;
      #3;
      checks++;
      if ({if_rsp_valid, d_rsp_valid, bus_req_valid, busy, if_rsp_err, d_rsp_err} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {if_rsp_valid, d_rsp_valid, bus_req_valid, busy, if_rsp_err, d_rsp_err});
      end
      checks++;
      if ({if_rsp_rdata, d_rsp_rdata, bus_req_addr, bus_req_wdata} !== 128'h0 || bus_req_be !== 4'h0) begin
         failures++;
         $display("FAIL reset_data got if=%h d=%h addr=%h be=%h exp=0",
                  if_rsp_rdata, d_rsp_rdata, bus_req_addr, bus_req_be);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      next_cycle();
      checks++;
      if ({if_req_ready, d_req_ready, busy} !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=000", {if_req_ready, d_req_ready, busy});
      end
      $display("txn reset done");
   endtask

   task automatic test_single_load();
      next_cycle();
      d_req_valid = 1; d_req_addr = 32'h100; d_req_we = 0;
      #1;
      checks++;
      if ({if_req_ready, d_req_ready} !== 2'b01) begin
         failures++;
         $display("FAIL load_grant got=%b exp=01", {if_req_ready, d_req_ready});
      end
      next_cycle();
      d_req_valid = 0; bus_req_ready = 1;
      #1;
      checks++;
      if (bus_req_valid !== 1'b1 || bus_req_addr !== 32'h100 || bus_req_we !== 1'b0) begin
         failures++;
         $display("FAIL load_bus_req got v=%b addr=%h we=%b exp v=1 addr=100 we=0",
                  bus_req_valid, bus_req_addr, bus_req_we);
      end
      next_cycle();
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (d_rsp_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL load_c2 got rsp=%b busy=%b exp rsp=0 busy=1", d_rsp_valid, busy);
      end
      next_cycle();
      bus_rsp_valid = 0;
      #1;
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'hDEADBEEF || d_rsp_err !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL load_rsp got v=%b rdata=%h err=%b busy=%b exp v=1 rdata=deadbeef err=0 busy=0",
                  d_rsp_valid, d_rsp_rdata, d_rsp_err, busy);
      end
      next_cycle();
      checks++;
      if (d_rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL load_pulse got=%b exp=0", d_rsp_valid);
      end
      $display("txn load addr=00000100 rdata=%h", d_rsp_rdata);
   endtask

   task automatic test_timeout();
      for (int v = 0; v < 2; v++) begin
         next_cycle();
         d_req_valid = 1; d_req_addr = 32'h200; d_req_we = 0;
         next_cycle();
         d_req_valid = 0; bus_req_ready = (v == 1);
         for (int k = 0; k < TMO; k++) begin
            #1;
            checks++;
            if (d_rsp_valid !== 1'b0 || busy !== 1'b1) begin
               failures++;
               $display("FAIL timeout_early v=%0d k=%0d got rsp=%b busy=%b exp rsp=0 busy=1",
                        v, k, d_rsp_valid, busy);
            end
            next_cycle();
            bus_req_ready = 0;
         end
         #1;
         checks++;
         if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_rdata !== 32'h0 ||
             busy !== 1'b0 || bus_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_rsp v=%0d got v=%b err=%b rdata=%h busy=%b breq=%b exp 1 1 0 0 0",
                     v, d_rsp_valid, d_rsp_err, d_rsp_rdata, busy, bus_req_valid);
         end
         $display("txn timeout variant=%0d err=%b", v, d_rsp_err);
      end
   endtask

   task automatic test_store();
      next_cycle();
      d_req_valid = 1; d_req_addr = 32'h300; d_req_we = 1; d_req_wdata = 32'h1234; d_req_be = 4'b0011;
      #1;
      checks++;
      if (d_req_ready !== 1'b1) begin
         failures++;
         $display("FAIL store_grant got=%b exp=1", d_req_ready);
      end
      next_cycle();
      d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0; d_req_be = 0;
      for (int k = 0; k < 4; k++) begin
         bus_req_ready = (k == 3);
         #1;
         checks++;
         if (bus_req_valid !== 1'b1 || bus_req_addr !== 32'h300 || bus_req_we !== 1'b1 ||
             bus_req_wdata !== 32'h1234 || bus_req_be !== 4'b0011) begin
            failures++;
            $display("FAIL store_stable k=%0d got v=%b addr=%h we=%b wdata=%h be=%b exp 1 300 1 1234 0011",
                     k, bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_be);
         end
         next_cycle();
      end
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_rdata = 0;
      #1;
      next_cycle();
      bus_rsp_valid = 0;
      #1;
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL store_rsp got v=%b err=%b exp v=1 err=0", d_rsp_valid, d_rsp_err);
      end
      $display("txn store addr=00000300 wdata=00001234 be=0011");
   endtask

   task automatic test_flush();
      next_cycle();
      if_req_valid = 1; if_req_addr = 32'h40;
      next_cycle();
      if_req_valid = 0; bus_req_ready = 1;
      #1;
      checks++;
      if (bus_req_addr !== 32'h40 || bus_req_we !== 1'b0 || bus_req_be !== 4'hF) begin
         failures++;
         $display("FAIL flush_fetch_req got addr=%h we=%b be=%b exp 40 0 1111",
                  bus_req_addr, bus_req_we, bus_req_be);
      end
      next_cycle();
      bus_req_ready = 0; if_flush = 1;
      next_cycle();
      if_flush = 0; bus_rsp_valid = 1; bus_rsp_rdata = 32'hCAFE0040;
      next_cycle();
      bus_rsp_valid = 0;
      #1;
      checks++;
      if (if_rsp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_drop got rsp=%b busy=%b exp rsp=0 busy=0", if_rsp_valid, busy);
      end
      next_cycle();
      if_flush = 1;
      next_cycle();
      if_flush = 0; if_req_valid = 1; if_req_addr = 32'h44;
      next_cycle();
      if_req_valid = 0; bus_req_ready = 1;
      next_cycle();
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_rdata = 32'h13579BDF;
      next_cycle();
      bus_rsp_valid = 0;
      #1;
      checks++;
      if (if_rsp_valid !== 1'b1 || if_rsp_rdata !== 32'h13579BDF || if_rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL flush_next got v=%b rdata=%h err=%b exp v=1 rdata=13579bdf err=0",
                  if_rsp_valid, if_rsp_rdata, if_rsp_err);
      end
      $display("txn flush dropped fetch 40, served fetch 44 rdata=%h", if_rsp_rdata);
   endtask

   task automatic test_reset_mid();
      next_cycle();
      d_req_valid = 1; d_req_addr = 32'h500;
      next_cycle();
      d_req_valid = 0; bus_req_ready = 1;
      next_cycle();
      bus_req_ready = 0;
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, bus_req_valid, d_rsp_valid, if_rsp_valid} !== 4'b0 || d_rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL rstmid_clear got=%b rdata=%h exp=0000 rdata=0",
                  {busy, bus_req_valid, d_rsp_valid, if_rsp_valid}, d_rsp_rdata);
      end
      next_cycle();
      reset = 1'b0; bus_rsp_valid = 1; bus_rsp_rdata = 32'hBAD0BAD0;
      next_cycle();
      bus_rsp_valid = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if ({busy, bus_req_valid, d_rsp_valid, if_rsp_valid} !== 4'b0 || d_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_late k=%0d got=%b rdata=%h exp=0000 rdata=0",
                     k, {busy, bus_req_valid, d_rsp_valid, if_rsp_valid}, d_rsp_rdata);
         end
         next_cycle();
      end
      $display("txn reset mid-transaction, late response ignored");
   endtask

   task automatic test_contention();
      int losses;
      bit vi, vd, exp_if;
      logic [31:0] ai, ad, rdat;
      apply_reset();
      next_cycle();
      losses = 0;
      for (int g = 0; g < 30; g++) begin
         if (g < 15) begin
            vi = 1; vd = 1;
         end else begin
            vi = 1'($urandom_range(0, 1));
            vd = 1'($urandom_range(0, 1));
            if (!vi && !vd) vd = 1;
         end
         ai = $urandom; ad = $urandom;
         if_req_valid = vi; if_req_addr = ai;
         d_req_valid = vd; d_req_addr = ad; d_req_we = 0;
         if (vi && (!vd || losses == MS)) begin
            exp_if = 1; losses = 0;
         end else begin
            exp_if = 0;
            if (vi) losses = losses + 1;
         end
         #1;
         checks++;
         if ({if_req_ready, d_req_ready} !== {exp_if, !exp_if}) begin
            failures++;
            $display("FAIL contention_grant g=%0d got=%b exp=%b", g,
                     {if_req_ready, d_req_ready}, {exp_if, !exp_if});
         end
         next_cycle();
         bus_req_ready = 1;
         #1;
         checks++;
         if (bus_req_addr !== (exp_if ? ai : ad)) begin
            failures++;
            $display("FAIL contention_addr g=%0d got=%h exp=%h", g, bus_req_addr, exp_if ? ai : ad);
         end
         next_cycle();
         bus_req_ready = 0; rdat = $urandom; bus_rsp_valid = 1; bus_rsp_rdata = rdat;
         next_cycle();
         bus_rsp_valid = 0;
         #1;
         checks++;
         if (if_rsp_valid !== exp_if || d_rsp_valid !== !exp_if ||
             (exp_if ? if_rsp_rdata : d_rsp_rdata) !== rdat) begin
            failures++;
            $display("FAIL contention_rsp g=%0d got if=%b d=%b ifd=%h dd=%h exp if=%b data=%h",
                     g, if_rsp_valid, d_rsp_valid, if_rsp_rdata, d_rsp_rdata, exp_if, rdat);
         end
         $display("txn grant g=%0d vi=%b vd=%b winner=%s", g, vi, vd, exp_if ? "IF" : "D");
      end
      if_req_valid = 0; d_req_valid = 0;
   endtask

   task automatic test_random();
      bit is_if, we, er, fl, fl_phase, exp_we, exp_if_v, exp_d_v;
      logic [31:0] a, wd, rdat;
      logic [3:0] be, exp_be;
      int rd, sd;
      for (int t = 0; t < 40; t++) begin
         is_if = 1'($urandom_range(0, 1));
         a = $urandom; wd = $urandom; rdat = $urandom;
         we = 1'($urandom_range(0, 1));
         be = 4'($urandom_range(0, 15));
         er = ($urandom_range(0, 7) == 0);
         rd = $urandom_range(0, 3);
         sd = $urandom_range(0, 3);
         fl = is_if && ($urandom_range(0, 3) == 0);
         fl_phase = 1'($urandom_range(0, 1));
         exp_we = is_if ? 1'b0 : we;
         exp_be = is_if ? 4'hF : be;
         next_cycle();
         if (is_if) begin
            if_req_valid = 1; if_req_addr = a;
         end else begin
            d_req_valid = 1; d_req_addr = a; d_req_we = we; d_req_wdata = wd; d_req_be = be;
         end
         if_flush = fl && !fl_phase;
         #1;
         checks++;
         if ({if_req_ready, d_req_ready} !== (is_if ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL random_grant t=%0d got=%b exp=%b", t, {if_req_ready, d_req_ready},
                     is_if ? 2'b10 : 2'b01);
         end
         next_cycle();
         if_req_valid = 0; d_req_valid = 0; if_flush = fl && fl_phase;
         for (int k = 0; k <= rd; k++) begin
            bus_req_ready = (k == rd);
            #1;
            checks++;
            if (bus_req_valid !== 1'b1 || bus_req_addr !== a || bus_req_we !== exp_we ||
                bus_req_be !== exp_be || (exp_we && bus_req_wdata !== wd)) begin
               failures++;
               $display("FAIL random_bus_req t=%0d got v=%b a=%h we=%b be=%b wd=%h exp a=%h we=%b be=%b wd=%h",
                        t, bus_req_valid, bus_req_addr, bus_req_we, bus_req_be, bus_req_wdata,
                        a, exp_we, exp_be, wd);
            end
            next_cycle();
            if_flush = 0;
         end
         bus_req_ready = 0;
         for (int k = 0; k <= sd; k++) begin
            bus_rsp_valid = (k == sd); bus_rsp_rdata = rdat; bus_rsp_err = er;
            #1;
            checks++;
            if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || busy !== 1'b1) begin
               failures++;
               $display("FAIL random_wait t=%0d got if=%b d=%b busy=%b exp 0 0 1",
                        t, if_rsp_valid, d_rsp_valid, busy);
            end
            next_cycle();
         end
         bus_rsp_valid = 0; bus_rsp_err = 0;
         #1;
         exp_if_v = is_if && !fl;
         exp_d_v = !is_if;
         checks++;
         if (if_rsp_valid !== exp_if_v || d_rsp_valid !== exp_d_v || busy !== 1'b0) begin
            failures++;
            $display("FAIL random_rsp_valid t=%0d got if=%b d=%b busy=%b exp if=%b d=%b busy=0",
                     t, if_rsp_valid, d_rsp_valid, busy, exp_if_v, exp_d_v);
         end
         if (exp_if_v) begin
            checks++;
            if (if_rsp_rdata !== rdat || if_rsp_err !== er) begin
               failures++;
               $display("FAIL random_if_data t=%0d got %h/%b exp %h/%b", t, if_rsp_rdata, if_rsp_err, rdat, er);
            end
         end
         if (exp_d_v) begin
            checks++;
            if (d_rsp_rdata !== rdat || d_rsp_err !== er) begin
               failures++;
               $display("FAIL random_d_data t=%0d got %h/%b exp %h/%b", t, d_rsp_rdata, d_rsp_err, rdat, er);
            end
         end
         $display("txn random t=%0d port=%s addr=%h we=%b rd=%0d sd=%0d err=%b flush=%b",
                  t, is_if ? "IF" : "D", a, exp_we, rd, sd, er, fl);
      end
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_timeout();
      test_store();
      test_flush();
      test_reset_mid();
      test_contention();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
